// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
package seg7_pkg;

    localparam int         MAX_DIGITS = 16;
    localparam logic [7:0] SEG_BLANK  = 8'hFF;

    // Active-low g..a patterns for hex digits 0..F (dp bit not included).
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E
    };

    // One-hot anode select for the given digit, optionally inverted.
    function automatic logic [MAX_DIGITS-1:0] an_onehot(input logic [3:0] idx,
                                                        input logic       active_low);
        logic [MAX_DIGITS-1:0] oh;
        oh = 16'b1 << idx;
        return active_low ? ~oh : oh;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display data/control bundle between the debug source and the scan driver.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_en;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    lz_en;
    logic [7:0]              seg;
    logic [NUM_DIGITS-1:0]   an;

    modport master (
        output load, value, dp_en, digit_en, lz_en,
        input  seg, an
    );

    modport slave (
        input  load, value, dp_en, digit_en, lz_en,
        output seg, an
    );
endinterface

// File: rtl/seg7_hex_lut.sv
// Hex nibble to active-low seven-segment pattern.
module seg7_hex_lut (
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);
    import seg7_pkg::*;

    assign pattern = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit seven-segment driver with guard blanking, per-digit
// dp/enable and optional leading-zero suppression. Outputs are registered.
module seg7_scan_driver #(
    parameter int NUM_DIGITS    = 8,
    parameter int CLK_DIV       = 50000,
    parameter bit AN_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    seg7_scan_driver_if.slave bus
);
    import seg7_pkg::*;

    localparam int                    IDX_W    = $clog2(NUM_DIGITS);
    localparam int                    CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW}};

    logic [CNT_W-1:0]        div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic [3:0] nibble;
    logic [6:0] pattern;
    logic       dp_sel;
    logic       en_sel;
    logic       supp_sel;
    logic       zero_run;

    seg7_hex_lut u_hex_lut (
        .nibble  (nibble),
        .pattern (pattern)
    );

    // Prescaler, digit index (explicit wrap) and shadow register update.
    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        idx_d     = idx_q;
        if (div_cnt_q == CNT_LAST) begin
            div_cnt_d = '0;
            idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        shadow_d = bus.load ? bus.value : shadow_q;
    end

    // Select the current digit's nibble/controls; walk from the top digit down
    // so zero_run says whether this digit and everything above it is zero.
    always_comb begin
        nibble   = 4'h0;
        dp_sel   = 1'b0;
        en_sel   = 1'b0;
        supp_sel = 1'b0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (shadow_q[4*i +: 4] == 4'h0);
            if (idx_q == IDX_W'(i)) begin
                nibble   = shadow_q[4*i +: 4];
                dp_sel   = bus.dp_en[i];
                en_sel   = bus.digit_en[i];
                supp_sel = bus.lz_en & zero_run & (i != 0);
            end
        end
    end

    // Next output drive: blank on the guard cycle and for dark/suppressed digits.
    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = AN_OFF;
        if ((div_cnt_q != '0) && en_sel && !supp_sel) begin
            seg_d = {~dp_sel, pattern};
            an_d  = NUM_DIGITS'(an_onehot(4'(idx_q), AN_ACTIVE_LOW));
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            seg_q     <= SEG_BLANK;
            an_q      <= AN_OFF;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 4-cycle dwell, active-low anodes.
module tb_seg7_scan_driver;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    seg7_scan_driver_if #(.NUM_DIGITS(4)) bus_if ();

    seg7_scan_driver #(
        .NUM_DIGITS    (4),
        .CLK_DIV       (4),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] s, input logic [3:0] a);
        check_val({tag, " seg"}, 32'(bus_if.seg), 32'(s));
        check_val({tag, " an"},  32'(bus_if.an),  32'(a));
    endtask

    // One digit slot: a guard cycle then three active cycles of the given drive.
    task automatic scan_digit(input string tag, input logic [7:0] s, input logic [3:0] a);
        @(negedge clk);
        check_out({tag, " guard"}, 8'hFF, 4'hF);
        bus_if.load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_out(tag, s, a);
        end
    endtask

    // Full scan starting at digit 1 (loads are applied at the digit 0 -> 1 boundary).
    task automatic frame(input string tag,
                         input logic [7:0] s1, input logic [3:0] a1,
                         input logic [7:0] s2, input logic [3:0] a2,
                         input logic [7:0] s3, input logic [3:0] a3,
                         input logic [7:0] s0, input logic [3:0] a0);
        scan_digit({tag, " d1"}, s1, a1);
        scan_digit({tag, " d2"}, s2, a2);
        scan_digit({tag, " d3"}, s3, a3);
        scan_digit({tag, " d0"}, s0, a0);
    endtask

    task automatic load_val(input logic [15:0] v);
        bus_if.value = v;
        bus_if.load  = 1'b1;
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        rst_n           = 1'b0;
        bus_if.load     = 1'b0;
        bus_if.value    = 16'h0000;
        bus_if.dp_en    = 4'b0000;
        bus_if.digit_en = 4'b1111;
        bus_if.lz_en    = 1'b0;

        // Reset held for three cycles.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_out("reset", 8'hFF, 4'hF);
        end

        // Release with a load of 12AF; first slot is the post-reset guard.
        rst_n = 1'b1;
        load_val(16'h12AF);
        scan_digit("scan d0", 8'h8E, 4'b1110);
        scan_digit("scan d1", 8'h88, 4'b1101);
        scan_digit("scan d2", 8'hA4, 4'b1011);
        scan_digit("scan d3", 8'hF9, 4'b0111);
        scan_digit("wrap d0", 8'h8E, 4'b1110);

        // Remaining hex patterns.
        load_val(16'h3456);
        frame("hex3456", 8'h92, 4'b1101, 8'h99, 4'b1011, 8'hB0, 4'b0111, 8'h82, 4'b1110);
        load_val(16'h789B);
        frame("hex789B", 8'h90, 4'b1101, 8'h80, 4'b1011, 8'hF8, 4'b0111, 8'h83, 4'b1110);
        load_val(16'hCDE0);
        frame("hexCDE0", 8'h86, 4'b1101, 8'hA1, 4'b1011, 8'hA7, 4'b0111, 8'hC0, 4'b1110);

        // Leading-zero suppression.
        bus_if.lz_en = 1'b1;
        load_val(16'h0030);
        frame("lz0030", 8'hB0, 4'b1101, 8'hFF, 4'hF, 8'hFF, 4'hF, 8'hC0, 4'b1110);
        load_val(16'h0000);
        frame("lz0000", 8'hFF, 4'hF, 8'hFF, 4'hF, 8'hFF, 4'hF, 8'hC0, 4'b1110);
        load_val(16'h1002);
        frame("lz1002", 8'hC0, 4'b1101, 8'hC0, 4'b1011, 8'hF9, 4'b0111, 8'hA4, 4'b1110);

        // Decimal point and per-digit enable.
        bus_if.lz_en    = 1'b0;
        bus_if.dp_en    = 4'b0010;
        bus_if.digit_en = 4'b1011;
        load_val(16'h12AF);
        frame("dpen", 8'h08, 4'b1101, 8'hFF, 4'hF, 8'hF9, 4'b0111, 8'h8E, 4'b1110);

        // Suppressed digits stay dark even with dp requested.
        bus_if.lz_en    = 1'b1;
        bus_if.dp_en    = 4'b1111;
        bus_if.digit_en = 4'b1111;
        load_val(16'h0000);
        frame("lzdp", 8'hFF, 4'hF, 8'hFF, 4'hF, 8'hFF, 4'hF, 8'h40, 4'b1110);

        // Mid-scan load during digit 1.
        bus_if.lz_en = 1'b0;
        bus_if.dp_en = 4'b0000;
        load_val(16'h12AF);
        @(negedge clk);
        check_out("mid guard", 8'hFF, 4'hF);
        bus_if.load = 1'b0;
        @(negedge clk);
        check_out("mid act1", 8'h88, 4'b1101);
        load_val(16'h0070);
        @(negedge clk);
        check_out("mid act2", 8'h88, 4'b1101);
        bus_if.load = 1'b0;
        @(negedge clk);
        check_out("mid act3", 8'hF8, 4'b1101);
        frame("mid cont", 8'hC0, 4'b1011, 8'hC0, 4'b0111, 8'hC0, 4'b1110, 8'hF8, 4'b1101);
        // frame() above ends after digit 1 here since it started at digit 2;
        // re-label: that call covered digits 2,3,0,1 in order.

        // Reset in the middle of digit 2.
        @(negedge clk);
        check_out("rst d2 guard", 8'hFF, 4'hF);
        @(negedge clk);
        check_out("rst d2 act", 8'hC0, 4'b1011);
        rst_n = 1'b0;
        @(negedge clk);
        check_out("rst mid", 8'hFF, 4'hF);
        rst_n = 1'b1;
        scan_digit("post rst d0", 8'hC0, 4'b1110);
        scan_digit("post rst d1", 8'hC0, 4'b1101);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Multiplexed N-digit seven-segment display driver for the board's status and debug display, for example PC or register contents from the MIPS core.
- Latches a packed hex value into a shadow register on a load strobe.
- Time-multiplexes the digits at a parametrised scan rate, with anti-ghosting blank guard, per-digit decimal point and enable, and optional leading-zero suppression.
- Sits between core debug outputs and the board's shared segment/anode pins.

Parameters:
NUM_DIGITS, 8, number of digits scanned; 2..16.
CLK_DIV, 50000, clk cycles each digit is selected, including 1 guard cycle; must be ≥ 2.
AN_ACTIVE_LOW, 1, 1 = anode enables driven active-low; 0 = active-high.

Ports:
clk, input, 1, system clock.
rst_n, input, 1, synchronous active-low reset.
load, input, 1, when high, shadow ← value at the clock edge.
value, input, 4*NUM_DIGITS, packed hex nibbles; digit i = value[4i+3:4i], digit 0 least significant.
dp_en, input, NUM_DIGITS, decimal point request per digit (1 = lit); sampled live.
digit_en, input, NUM_DIGITS, per-digit enable (0 = digit dark); sampled live.
lz_en, input, 1, leading-zero suppression enable; sampled live.
seg, output, 8, segment drive, active-low; bit7 = dp, bits6..0 = g,f,e,d,c,b,a.
an, output, NUM_DIGITS, one-hot digit select, polarity per AN_ACTIVE_LOW.

Behaviour:
- One clock; reset is synchronous and active-low (clk, rst_n).
- Reset values:
  - div_cnt = 0, idx = 0, shadow = 0.
  - seg = 8'hFF.
  - an = all off (all ones if AN_ACTIVE_LOW, else all zeros).
- Prescaler:
  - div_cnt counts 0..CLK_DIV-1.
  - At CLK_DIV-1, div_cnt ← 0 and idx ← idx+1.
  - idx wraps NUM_DIGITS-1 → 0.
- Outputs are registered. The value computed from (div_cnt, idx, shadow, inputs) in cycle t appears on seg/an in cycle t+1.
- Guard cycle: when div_cnt == 0, next an = all off and next seg = 8'hFF.
- Active cycles: when div_cnt ≥ 1, digit idx is shown unless blanked.
  - Shown: an = one-hot idx; seg[6:0] = hex pattern of shadow nibble idx; seg[7] = ~dp_en[idx].
  - Blanked when digit_en[idx] == 0, or when suppressed by leading-zero logic: an all off, seg = 8'hFF.
- Hex patterns (seg[6:0] with bit7 = 1 shown):
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8
  - 8 80, 9 90, A 88, b 83, c A7, d A1, E 86, F 8E
- Leading-zero suppression, when lz_en = 1:
  - Digit i > 0 is suppressed if shadow nibbles i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never suppressed, so a value of 0 shows a single "0".
  - A suppressed digit is fully blank, including dp, even if dp_en = 1.
- load:
  - Updates shadow at the edge and affects outputs from the next cycle.
  - Mid-scan load does not reset div_cnt or idx.
  - load held high makes shadow track value with one cycle of delay.
- Reset mid-scan: at the next edge all state returns to reset values; scan restarts at digit 0 with a guard cycle.
- Widths: idx is $clog2(NUM_DIGITS) bits and div_cnt is $clog2(CLK_DIV) bits. For a non-power-of-2 NUM_DIGITS, wrap is by explicit compare.

Decomposition:
- Package seg7_pkg holds:
  - SEG_BLANK = 8'hFF.
  - HEX_SEG[16] pattern constant array.
  - Function an_onehot(idx, active_low).
- One sub-module, seg7_hex_lut: combinational, 4-bit nibble → 7-bit active-low pattern from HEX_SEG.
- Prescaler, scan index, leading-zero logic and output registers stay in seg7_scan_driver.

Test Plan:
All scenarios use NUM_DIGITS = 4, CLK_DIV = 4, AN_ACTIVE_LOW = 1.
1. Reset: rst_n = 0 for 3 cycles, then release → seg = FF and an = 4'b1111 during and 1 cycle after reset. First lit cycle shows an = 4'b1110.
2. Scan: load value = 16'h12AF, all enables 1, dp_en = 0 → per digit, 1 guard cycle (FF/1111) then 3 cycles of:
   - 8E with an 1110,
   - 88 with an 1101,
   - A4 with an 1011,
   - F9 with an 0111.
   Wraps to digit 0 after 16 cycles.
3. Leading zeros: value = 16'h0030, lz_en = 1 → digits 3 and 2 dark (FF/1111), digit 1 = B0, digit 0 = C0. value = 0 → only digit 0 = C0.
4. dp and enable: dp_en = 4'b0010, digit_en = 4'b1011 → digit 1 seg[7] = 0; digit 2 dark for all its cycles; the others unchanged.
5. Mid-scan load: during digit 1, active cycle 2, load 16'h0070 → next cycle digit 1 pattern = F8. idx and div_cnt sequence is not disturbed.
6. Reset mid-scan during digit 2 → next cycle FF/1111. Scan restarts at digit 0 with shadow = 0 (C0).
